// File: rtl/fetch_control_unit_pkg.sv
// Shared definitions for the BIP fetch/control unit: widths, opcodes,
// FSM encoding, datapath select encodings and the decoded control bundle.
package fetch_control_unit_pkg;

  localparam int DEF_PC_W    = 11;
  localparam int DEF_INSTR_W = 16;
  localparam int DEF_OPC_W   = 5;

  localparam logic [4:0] OPC_HLT  = 5'b00000;
  localparam logic [4:0] OPC_STO  = 5'b00001;
  localparam logic [4:0] OPC_LD   = 5'b00010;
  localparam logic [4:0] OPC_LDI  = 5'b00011;
  localparam logic [4:0] OPC_ADD  = 5'b00100;
  localparam logic [4:0] OPC_ADDI = 5'b00101;
  localparam logic [4:0] OPC_SUB  = 5'b00110;
  localparam logic [4:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STEP   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  localparam logic [1:0] SEL_A_RAM = 2'd0;
  localparam logic [1:0] SEL_A_IMM = 2'd1;
  localparam logic [1:0] SEL_A_ALU = 2'd2;
  localparam logic       SEL_B_RAM = 1'b0;
  localparam logic       SEL_B_IMM = 1'b1;

  typedef struct packed {
    logic       wr_ram;
    logic       rd_ram;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op_sub;
  } ctrl_t;

endpackage

// File: rtl/fetch_control_unit_if.sv
// Bus between the fetch/control unit and its environment: run control,
// program memory port and the one-cycle datapath control pulses.
interface fetch_control_unit_if
  import fetch_control_unit_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W   = DEF_OPC_W
);
  logic               start;
  logic               step_mode;
  logic               step;
  logic [INSTR_W-1:0] instr;
  logic [PC_W-1:0]    pc;
  logic               op_valid;
  logic [OPC_W-1:0]   opcode;
  logic [PC_W-1:0]    operand;
  logic               wr_ram;
  logic               rd_ram;
  logic [1:0]         sel_a;
  logic               sel_b;
  logic               wr_acc;
  logic               op_sub;
  logic               running;
  logic               halted;

  modport master (
    output start, step_mode, step, instr,
    input  pc, op_valid, opcode, operand, wr_ram, rd_ram, sel_a, sel_b,
           wr_acc, op_sub, running, halted
  );

  modport slave (
    input  start, step_mode, step, instr,
    output pc, op_valid, opcode, operand, wr_ram, rd_ram, sel_a, sel_b,
           wr_acc, op_sub, running, halted
  );

endinterface

// File: rtl/fetch_control_unit_instruction_decoder.sv
// Purely combinational opcode -> datapath control decode. Unknown opcodes
// decode to all-zero controls so they behave as NOPs.
module instruction_decoder
  import fetch_control_unit_pkg::*;
(
  input  logic [DEF_OPC_W-1:0] i_opcode,
  output ctrl_t                o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_opcode)
      OPC_STO: begin
        o_ctrl.wr_ram = 1'b1;
      end
      OPC_LD: begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.sel_a  = SEL_A_RAM;
        o_ctrl.wr_acc = 1'b1;
      end
      OPC_LDI: begin
        o_ctrl.sel_a  = SEL_A_IMM;
        o_ctrl.wr_acc = 1'b1;
      end
      OPC_ADD: begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.sel_a  = SEL_A_ALU;
        o_ctrl.sel_b  = SEL_B_RAM;
        o_ctrl.wr_acc = 1'b1;
      end
      OPC_ADDI: begin
        o_ctrl.sel_a  = SEL_A_ALU;
        o_ctrl.sel_b  = SEL_B_IMM;
        o_ctrl.wr_acc = 1'b1;
      end
      OPC_SUB: begin
        o_ctrl.rd_ram = 1'b1;
        o_ctrl.sel_a  = SEL_A_ALU;
        o_ctrl.sel_b  = SEL_B_RAM;
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.op_sub = 1'b1;
      end
      OPC_SUBI: begin
        o_ctrl.sel_a  = SEL_A_ALU;
        o_ctrl.sel_b  = SEL_B_IMM;
        o_ctrl.wr_acc = 1'b1;
        o_ctrl.op_sub = 1'b1;
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/fetch_control_unit.sv
// Fetch/control sequencer for the BIP core: owns the PC, runs free or
// single-step, and turns each executed instruction into one control pulse.
module fetch_control_unit
  import fetch_control_unit_pkg::*;
#(
  parameter int PC_W    = DEF_PC_W,
  parameter int INSTR_W = DEF_INSTR_W,
  parameter int OPC_W   = DEF_OPC_W
)(
  input  logic                 clk,
  input  logic                 rst_n,
  fetch_control_unit_if.slave  bus
);

  logic [1:0]       r_state;
  logic [PC_W-1:0]  r_pc;
  logic             r_step_q;
  logic             r_op_valid;
  logic [OPC_W-1:0] r_opcode;
  logic [PC_W-1:0]  r_operand;
  ctrl_t            r_ctrl;

  logic [OPC_W-1:0] w_opcode;
  logic [PC_W-1:0]  w_operand;
  ctrl_t            w_ctrl;
  logic             w_exec;
  logic             w_is_hlt;

  assign w_opcode  = bus.instr[INSTR_W-1 -: OPC_W];
  assign w_operand = bus.instr[PC_W-1:0];
  assign w_is_hlt  = (w_opcode == OPC_HLT);

  // In step mode only a rising edge of the step level executes, so a held step runs one instruction.
  assign w_exec = (r_state == ST_RUN) |
                  ((r_state == ST_STEP) & bus.step & ~r_step_q);

  instruction_decoder u_decoder (
    .i_opcode (w_opcode),
    .o_ctrl   (w_ctrl)
  );

  // Controls default to zero every cycle so they only ever appear as single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_pc       <= '0;
      r_step_q   <= 1'b0;
      r_op_valid <= 1'b0;
      r_opcode   <= '0;
      r_operand  <= '0;
      r_ctrl     <= '0;
    end else begin
      r_step_q   <= bus.step;
      r_op_valid <= 1'b0;
      r_ctrl     <= '0;
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_state <= bus.step_mode ? ST_STEP : ST_RUN;
          end
        end
        ST_HALTED: begin
          if (bus.start) begin
            r_pc    <= '0;
            r_state <= bus.step_mode ? ST_STEP : ST_RUN;
          end
        end
        ST_RUN, ST_STEP: begin
          if (w_exec) begin
            if (w_is_hlt) begin
              r_state <= ST_HALTED;
            end else begin
              r_pc       <= r_pc + 1'b1;
              r_op_valid <= 1'b1;
              r_opcode   <= w_opcode;
              r_operand  <= w_operand;
              r_ctrl     <= w_ctrl;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.pc       = r_pc;
  assign bus.op_valid = r_op_valid;
  assign bus.opcode   = r_opcode;
  assign bus.operand  = r_operand;
  assign bus.wr_ram   = r_ctrl.wr_ram;
  assign bus.rd_ram   = r_ctrl.rd_ram;
  assign bus.sel_a    = r_ctrl.sel_a;
  assign bus.sel_b    = r_ctrl.sel_b;
  assign bus.wr_acc   = r_ctrl.wr_acc;
  assign bus.op_sub   = r_ctrl.op_sub;
  assign bus.running  = (r_state == ST_RUN) | (r_state == ST_STEP);
  assign bus.halted   = (r_state == ST_HALTED);

endmodule

// File: tb/tb_fetch_control_unit.sv
// Self-checking bench for fetch_control_unit: directed program scenarios plus
// a randomized phase, all compared against an instruction-level reference model.
module tb_fetch_control_unit;

  localparam int MEM_DEPTH = 2048;
  localparam int M_IDLE = 0, M_RUN = 1, M_STEP = 2, M_HALT = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_control_unit_if ifc ();

  fetch_control_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  logic [15:0] prog [MEM_DEPTH];
  always_comb ifc.instr = prog[ifc.pc];

  int errors = 0;
  int checks = 0;

  int         mMode;
  int         mPc;
  bit         mStepQ;
  bit         eValid;
  logic [6:0] eCtrl;
  logic [4:0] eOpc;
  logic [10:0] eOperand;
  int         validCount;

  function automatic logic [15:0] mkInstr(input int opc, input int arg);
    logic [15:0] w;
    w[15:11] = opc[4:0];
    w[10:0]  = arg[10:0];
    return w;
  endfunction

  // Expected control vector {wr_ram, rd_ram, sel_a[1:0], sel_b, wr_acc, op_sub} from the opcode table
  function automatic logic [6:0] expectCtrl(input logic [4:0] opc);
    logic       wrRam, rdRam, selB, wrAcc, opSub;
    logic [1:0] selA;
    wrRam = (opc == 5'd1);
    rdRam = (opc == 5'd2) || (opc == 5'd4) || (opc == 5'd6);
    wrAcc = (opc >= 5'd2) && (opc <= 5'd7);
    opSub = (opc == 5'd6) || (opc == 5'd7);
    selB  = (opc == 5'd5) || (opc == 5'd7);
    if (opc == 5'd3)                     selA = 2'd1;
    else if (opc >= 5'd4 && opc <= 5'd7) selA = 2'd2;
    else                                 selA = 2'd0;
    return {wrRam, rdRam, selA, selB, wrAcc, opSub};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h at t=%0t", tag, observed, expected, $time);
    end
  endtask

  task automatic checkAll();
    checkOutput("pc", 32'(ifc.pc), 32'(mPc));
    checkOutput("op_valid", 32'(ifc.op_valid), 32'(eValid));
    checkOutput("ctrl", 32'({ifc.wr_ram, ifc.rd_ram, ifc.sel_a, ifc.sel_b, ifc.wr_acc, ifc.op_sub}), 32'(eCtrl));
    checkOutput("running", 32'(ifc.running), 32'((mMode == M_RUN) || (mMode == M_STEP)));
    checkOutput("halted", 32'(ifc.halted), 32'(mMode == M_HALT));
    if (eValid) begin
      checkOutput("opcode", 32'(ifc.opcode), 32'(eOpc));
      checkOutput("operand", 32'(ifc.operand), 32'(eOperand));
    end
  endtask

  // Advance one clock: update the model from pre-edge inputs, then compare just after the edge
  task automatic tick();
    logic [15:0] ins;
    logic [4:0]  opc;
    bit          ex;
    @(posedge clk);
    ins = prog[mPc];
    opc = ins[15:11];
    ex  = (mMode == M_RUN) || (mMode == M_STEP && ifc.step && !mStepQ);
    eValid = 1'b0;
    eCtrl  = '0;
    if (mMode == M_IDLE || mMode == M_HALT) begin
      if (ifc.start) begin
        if (mMode == M_HALT) mPc = 0;
        mMode = ifc.step_mode ? M_STEP : M_RUN;
      end
    end else if (ex) begin
      if (opc == 5'd0) begin
        mMode = M_HALT;
      end else begin
        mPc      = (mPc + 1) % MEM_DEPTH;
        eValid   = 1'b1;
        eOpc     = opc;
        eOperand = ins[10:0];
        eCtrl    = expectCtrl(opc);
      end
    end
    mStepQ = ifc.step;
    #1;
    if (ifc.op_valid) validCount++;
    checkAll();
  endtask

  task automatic applyStimulus(input bit st, input bit sm, input bit stp);
    ifc.start     = st;
    ifc.step_mode = sm;
    ifc.step      = stp;
    tick();
  endtask

  task automatic doReset();
    ifc.start = 1'b0;
    ifc.step  = 1'b0;
    rst_n     = 1'b0;
    mMode  = M_IDLE;
    mPc    = 0;
    mStepQ = 1'b0;
    eValid = 1'b0;
    eCtrl  = '0;
    #2;
    checkAll();
    rst_n = 1'b1;
  endtask

  initial begin
    bit stepLvl;
    rst_n = 1'b1;
    ifc.start = 1'b0;
    ifc.step_mode = 1'b0;
    ifc.step = 1'b0;
    for (int i = 0; i < MEM_DEPTH; i++) prog[i] = 16'h0000;
    #1;
    doReset();

    $display("[TB] free-run program LDI/ADDI/STO/HLT");
    prog[0] = mkInstr(3, 5);
    prog[1] = mkInstr(5, 3);
    prog[2] = mkInstr(1, 10);
    prog[3] = mkInstr(0, 0);
    validCount = 0;
    applyStimulus(1, 0, 0);
    repeat (5) applyStimulus(0, 0, 0);
    checkOutput("t1_pulses", 32'(validCount), 32'd3);
    checkOutput("t1_pc", 32'(ifc.pc), 32'd3);
    checkOutput("t1_halted", 32'(ifc.halted), 32'd1);

    $display("[TB] restart from halted");
    applyStimulus(1, 0, 0);
    checkOutput("t5_pc0", 32'(ifc.pc), 32'd0);
    checkOutput("t5_running", 32'(ifc.running), 32'd1);
    applyStimulus(0, 0, 0);
    checkOutput("t5_reexec", 32'({ifc.op_valid, ifc.opcode}), 32'({1'b1, 5'd3}));
    repeat (4) applyStimulus(0, 0, 0);

    $display("[TB] every opcode individually");
    prog[0] = mkInstr(1, $urandom_range(0, 2047));
    prog[1] = mkInstr(2, $urandom_range(0, 2047));
    prog[2] = mkInstr(3, $urandom_range(0, 2047));
    prog[3] = mkInstr(4, $urandom_range(0, 2047));
    prog[4] = mkInstr(5, $urandom_range(0, 2047));
    prog[5] = mkInstr(6, $urandom_range(0, 2047));
    prog[6] = mkInstr(7, $urandom_range(0, 2047));
    prog[7] = mkInstr(31, $urandom_range(0, 2047));
    prog[8] = mkInstr(0, 0);
    applyStimulus(1, 0, 0);
    repeat (11) applyStimulus(0, 0, 0);

    $display("[TB] single-step with held step");
    validCount = 0;
    applyStimulus(1, 1, 0);
    repeat (10) applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);
    checkOutput("t2_issued", 32'(validCount), 32'd3);
    checkOutput("t2_pc", 32'(ifc.pc), 32'd3);

    $display("[TB] async reset mid-run");
    doReset();
    applyStimulus(1, 0, 0);
    repeat (7) applyStimulus(0, 0, 0);
    checkOutput("t4_pc7", 32'(ifc.pc), 32'd7);
    doReset();
    checkOutput("t4_pc_async", 32'(ifc.pc), 32'd0);
    applyStimulus(0, 0, 0);

    $display("[TB] start with simultaneous step edge from idle");
    applyStimulus(1, 1, 1);
    applyStimulus(0, 1, 1);
    checkOutput("idle_step_pc", 32'(ifc.pc), 32'd0);
    applyStimulus(0, 1, 0);
    applyStimulus(0, 1, 1);

    $display("[TB] pc wrap with NOPs");
    for (int i = 0; i < MEM_DEPTH; i++) prog[i] = mkInstr(31, $urandom_range(0, 2047));
    doReset();
    validCount = 0;
    applyStimulus(1, 0, 0);
    repeat (MEM_DEPTH + 2) applyStimulus(0, 0, 0);
    checkOutput("t3_valid_all", 32'(validCount), 32'(MEM_DEPTH + 2));
    checkOutput("t3_wrap_pc", 32'(ifc.pc), 32'd2);

    $display("[TB] randomized run");
    for (int i = 0; i < MEM_DEPTH; i++) begin
      int r;
      r = $urandom_range(0, 11);
      if (r >= 8) prog[i] = mkInstr($urandom_range(8, 31), $urandom_range(0, 2047));
      else        prog[i] = mkInstr(r, $urandom_range(0, 2047));
    end
    doReset();
    stepLvl = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        doReset();
        stepLvl = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) stepLvl = ~stepLvl;
      applyStimulus(($urandom_range(0, 11) == 0), 1'($urandom_range(0, 1)), stepLvl);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
